// File: rtl/psram_arb_pkg.sv
// Shared types and constants for the PSRAM port arbiter.
package psram_arb_pkg;

    localparam int PSRAM_ADDR_W      = 24;
    localparam int PSRAM_DATA_W      = 16;
    localparam int PSRAM_ARB_TIMEOUT = 4095;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_ISSUE     = 3'd1,
        ST_SETTLE    = 3'd2,
        ST_WAIT_BUSY = 3'd3,
        ST_RESP      = 3'd4
    } psram_arb_state_t;

endpackage

// File: rtl/psram_arb_rr_arb2.sv
// Two-requester round-robin grant: a lone requester always wins, a tie goes
// to the port that did not win last time.
module rr_arb2 (
    input  logic [1:0] req,
    input  logic       last,
    output logic [1:0] gnt
);

    // Tie-break against the previous winner, otherwise pass the request through.
    always_comb begin
        gnt = 2'b00;
        if (req == 2'b11) begin
            gnt = last ? 2'b01 : 2'b10;
        end else begin
            gnt = req;
        end
    end

endmodule

// File: rtl/psram_arb.sv
// Round-robin arbiter and strobe sequencer sharing one PSRAM controller
// between two masters, with a hang timeout on the controller busy flag.
module psram_arb
    import psram_arb_pkg::*;
#(
    parameter int ADDR_W      = PSRAM_ADDR_W,
    parameter int DATA_W      = PSRAM_DATA_W,
    parameter int TIMEOUT_CYC = PSRAM_ARB_TIMEOUT
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [1:0]          req_valid,
    input  logic [1:0]          req_we,
    input  logic [2*ADDR_W-1:0] req_addr,
    input  logic [2*DATA_W-1:0] req_wdat,
    output logic [1:0]          req_ready,
    output logic [1:0]          rsp_valid,
    output logic                rsp_err,
    output logic [DATA_W-1:0]   rsp_rdat,
    output logic                psram_stb,
    output logic                psram_we,
    output logic [ADDR_W-1:0]   psram_addr,
    output logic [DATA_W-1:0]   psram_din,
    input  logic                psram_busy,
    input  logic [DATA_W-1:0]   psram_dout,
    output logic                arb_busy
);

    localparam int CNT_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);

    psram_arb_state_t  state_q, state_d;
    logic              last_q, last_d;
    logic              owner_q, owner_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdat_q, wdat_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              err_q, err_d;
    logic [DATA_W-1:0] rdat_q, rdat_d;

    logic [1:0]        gnt;
    logic              gnt_idx;

    rr_arb2 u_rr (
        .req  (req_valid),
        .last (last_q),
        .gnt  (gnt)
    );

    // gnt is one-hot or zero, so bit 1 alone names the winning port.
    assign gnt_idx = gnt[1];

    // Next-state logic: grant and capture, strobe, settle, wait, respond.
    always_comb begin
        state_d = state_q;
        last_d  = last_q;
        owner_d = owner_q;
        we_d    = we_q;
        addr_d  = addr_q;
        wdat_d  = wdat_q;
        cnt_d   = cnt_q;
        err_d   = err_q;
        rdat_d  = rdat_q;
        case (state_q)
            ST_IDLE: begin
                if (gnt != 2'b00) begin
                    owner_d = gnt_idx;
                    last_d  = gnt_idx;
                    we_d    = req_we[gnt_idx];
                    addr_d  = req_addr[gnt_idx*ADDR_W +: ADDR_W];
                    wdat_d  = req_wdat[gnt_idx*DATA_W +: DATA_W];
                    state_d = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                state_d = ST_SETTLE;
            end
            ST_SETTLE: begin
                cnt_d   = '0;
                state_d = ST_WAIT_BUSY;
            end
            ST_WAIT_BUSY: begin
                if (!psram_busy) begin
                    if (!we_q) begin
                        rdat_d = psram_dout;
                    end
                    state_d = ST_RESP;
                end else if (cnt_q == CNT_LAST) begin
                    err_d   = 1'b1;
                    state_d = ST_RESP;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_RESP: begin
                err_d   = 1'b0;
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and capture registers; reset drops any transaction in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            last_q  <= 1'b1;
            owner_q <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdat_q  <= '0;
            cnt_q   <= '0;
            err_q   <= 1'b0;
            rdat_q  <= '0;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            owner_q <= owner_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdat_q  <= wdat_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
            rdat_q  <= rdat_d;
        end
    end

    // Outputs decoded from state; ready is suppressed during reset so a
    // requester never sees an accept that the reset then discards.
    always_comb begin
        req_ready  = (state_q == ST_IDLE && !rst) ? gnt : 2'b00;
        rsp_valid  = 2'b00;
        if (state_q == ST_RESP) begin
            rsp_valid = owner_q ? 2'b10 : 2'b01;
        end
        rsp_err    = (state_q == ST_RESP) && err_q;
        rsp_rdat   = rdat_q;
        psram_stb  = (state_q == ST_ISSUE);
        psram_we   = (state_q == ST_ISSUE) && we_q;
        psram_addr = addr_q;
        psram_din  = wdat_q;
        arb_busy   = (state_q != ST_IDLE);
    end

endmodule

// File: tb/tb_psram_arb.sv
// Directed bench for psram_arb: vector table of single transactions, then
// hand-written reset-in-flight and fairness sequences.
module tb_psram_arb;

    localparam int AW = 24;
    localparam int DW = 16;
    localparam int TO = 8;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [1:0]    req_valid = '0;
    logic [1:0]    req_we = '0;
    logic [2*AW-1:0] req_addr = '0;
    logic [2*DW-1:0] req_wdat = '0;
    logic [1:0]    req_ready;
    logic [1:0]    rsp_valid;
    logic          rsp_err;
    logic [DW-1:0] rsp_rdat;
    logic          psram_stb;
    logic          psram_we;
    logic [AW-1:0] psram_addr;
    logic [DW-1:0] psram_din;
    logic          psram_busy = 1'b0;
    logic [DW-1:0] psram_dout = '0;
    logic          arb_busy;

    psram_arb #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT_CYC(TO)) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_we     (req_we),
        .req_addr   (req_addr),
        .req_wdat   (req_wdat),
        .req_ready  (req_ready),
        .rsp_valid  (rsp_valid),
        .rsp_err    (rsp_err),
        .rsp_rdat   (rsp_rdat),
        .psram_stb  (psram_stb),
        .psram_we   (psram_we),
        .psram_addr (psram_addr),
        .psram_din  (psram_din),
        .psram_busy (psram_busy),
        .psram_dout (psram_dout),
        .arb_busy   (arb_busy)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    // Controller model: busy rises at the strobe and stays for busy_len
    // falling edges (counting the strobe cycle).
    int          busy_len = 0;
    int          busy_left = 0;
    int          stb_count = 0;
    int          cyc = 0;
    int          stb_cyc[$];
    logic [AW-1:0] stb_addr = '0;
    logic        stb_we = 1'b0;
    logic [DW-1:0] stb_din = '0;
    logic [DW-1:0] model_dout = '0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (psram_stb) begin
            busy_left = busy_len;
            stb_count = stb_count + 1;
            stb_addr  = psram_addr;
            stb_we    = psram_we;
            stb_din   = psram_din;
            stb_cyc.push_back(cyc);
        end else if (busy_left > 0) begin
            busy_left = busy_left - 1;
        end
        psram_busy = (busy_left > 0);
        psram_dout = model_dout;
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", nm, act, exp);
        end
    endtask

    task automatic chk_idle_outputs(input string nm);
        chk({nm, " req_ready"}, {30'd0, req_ready}, 0);
        chk({nm, " rsp_valid"}, {30'd0, rsp_valid}, 0);
        chk({nm, " rsp_err"}, {31'd0, rsp_err}, 0);
        chk({nm, " rsp_rdat"}, {16'd0, rsp_rdat}, 0);
        chk({nm, " psram_stb"}, {31'd0, psram_stb}, 0);
        chk({nm, " psram_we"}, {31'd0, psram_we}, 0);
        chk({nm, " psram_addr"}, {8'd0, psram_addr}, 0);
        chk({nm, " psram_din"}, {16'd0, psram_din}, 0);
        chk({nm, " arb_busy"}, {31'd0, arb_busy}, 0);
    endtask

    typedef struct {
        int          port;
        logic        we;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdat;
        logic [DW-1:0] dout;
        int          len;
        logic [DW-1:0] exp_rdat;
        logic        exp_err;
        int          exp_lat;
    } vec_t;

    task automatic run_txn(input int idx, input vec_t v);
        int t;
        int lat;
        int s0;
        model_dout = v.dout;
        busy_len   = v.len;
        s0         = stb_count;
        @(negedge clk);
        req_valid[v.port] = 1'b1;
        req_we[v.port]    = v.we;
        req_addr[v.port*AW +: AW] = v.addr;
        req_wdat[v.port*DW +: DW] = v.wdat;
        #1;
        t = 0;
        while (req_ready == 2'b00 && t < 20) begin
            @(negedge clk);
            #1;
            t++;
        end
        chk($sformatf("v%0d ready", idx), {30'd0, req_ready}, 32'd1 << v.port);
        if (req_ready == 2'b00) begin
            req_valid = '0;
            return;
        end
        @(posedge clk);
        @(negedge clk);
        req_valid = '0;
        lat = 1;
        while (rsp_valid == 2'b00 && lat < 60) begin
            @(negedge clk);
            lat++;
        end
        chk($sformatf("v%0d latency", idx), lat, v.exp_lat);
        chk($sformatf("v%0d rsp_valid", idx), {30'd0, rsp_valid}, 32'd1 << v.port);
        chk($sformatf("v%0d rsp_rdat", idx), {16'd0, rsp_rdat}, {16'd0, v.exp_rdat});
        chk($sformatf("v%0d rsp_err", idx), {31'd0, rsp_err}, {31'd0, v.exp_err});
        chk($sformatf("v%0d stb count", idx), stb_count - s0, 1);
        chk($sformatf("v%0d stb addr", idx), {8'd0, stb_addr}, {8'd0, v.addr});
        chk($sformatf("v%0d stb we", idx), {31'd0, stb_we}, {31'd0, v.we});
        chk($sformatf("v%0d stb din", idx), {16'd0, stb_din}, {16'd0, v.wdat});
        $display("txn %0d: port %0d we %0d addr 0x%06h lat %0d rdat 0x%04h err %0d",
                 idx, v.port, v.we, v.addr, lat, rsp_rdat, rsp_err);
        @(negedge clk);
        chk($sformatf("v%0d rsp pulse width", idx), {30'd0, rsp_valid}, 0);
        chk($sformatf("v%0d arb_busy after", idx), {31'd0, arb_busy}, 0);
    endtask

    vec_t vecs[6];

    initial begin : main
        int t;
        int ngr;
        int nrsp;
        int lat;
        logic stop_after;
        logic seen_rsp;
        logic gq[6];
        logic rq[6];

        vecs[0] = '{0, 1'b0, 24'h000123, 16'h0000, 16'hBEEF, 5,   16'hBEEF, 1'b0, 7};
        vecs[1] = '{1, 1'b1, 24'hABCDEF, 16'h5A5A, 16'h1111, 3,   16'hBEEF, 1'b0, 5};
        vecs[2] = '{1, 1'b0, 24'h000456, 16'h0000, 16'h1234, 0,   16'h1234, 1'b0, 4};
        vecs[3] = '{0, 1'b1, 24'h00FFFF, 16'hC3C3, 16'h2222, 2,   16'h1234, 1'b0, 4};
        vecs[4] = '{0, 1'b0, 24'h123456, 16'h0000, 16'h7777, 100, 16'h1234, 1'b1, 3 + TO};
        vecs[5] = '{1, 1'b0, 24'h654321, 16'h0000, 16'h9999, 1,   16'h9999, 1'b0, 4};

        // Reset state
        repeat (3) @(negedge clk);
        chk_idle_outputs("reset");
        rst = 1'b0;
        @(negedge clk);
        chk_idle_outputs("post-reset");

        // Vector table
        for (int i = 0; i < 6; i++) begin
            run_txn(i, vecs[i]);
        end

        // Reset while waiting on busy: nothing returned, port 0 wins next tie
        busy_len = 20;
        @(negedge clk);
        req_valid[1] = 1'b1;
        req_we[1]    = 1'b0;
        req_addr[AW +: AW] = 24'h0000AA;
        #1;
        chk("rst-seq ready", {30'd0, req_ready}, 2);
        @(posedge clk);
        @(negedge clk);
        req_valid = '0;
        @(negedge clk);
        @(negedge clk);
        chk("rst-seq busy in wait", {31'd0, arb_busy}, 1);
        rst = 1'b1;
        @(negedge clk);
        chk_idle_outputs("rst-seq");
        rst = 1'b0;
        seen_rsp = 1'b0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (rsp_valid != 2'b00) seen_rsp = 1'b1;
        end
        chk("rst-seq no rsp", {31'd0, seen_rsp}, 0);
        busy_len = 0;
        model_dout = 16'h4321;
        req_valid = 2'b11;
        req_we = 2'b00;
        #1;
        chk("rst-seq first grant", {30'd0, req_ready}, 1);
        @(posedge clk);
        @(negedge clk);
        req_valid = '0;
        lat = 1;
        while (rsp_valid == 2'b00 && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        chk("rst-seq rsp port", {30'd0, rsp_valid}, 1);
        chk("rst-seq min latency", lat, 4);
        chk("rst-seq rdat", {16'd0, rsp_rdat}, 32'h4321);
        $display("txn rst-seq: port 0 read after reset lat %0d rdat 0x%04h", lat, rsp_rdat);

        // Fairness with both ports held valid
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        stb_cyc.delete();
        busy_len = 0;
        req_valid = 2'b11;
        req_we = 2'b00;
        ngr = 0;
        nrsp = 0;
        t = 0;
        stop_after = 1'b0;
        while ((ngr < 6 || nrsp < 6) && t < 200) begin
            #1;
            if (req_ready != 2'b00 && ngr < 6) begin
                gq[ngr] = req_ready[1];
                ngr++;
                if (ngr == 6) stop_after = 1'b1;
            end
            if (rsp_valid != 2'b00 && nrsp < 6) begin
                rq[nrsp] = rsp_valid[1];
                nrsp++;
            end
            @(negedge clk);
            t++;
            if (stop_after) begin
                req_valid = '0;
                stop_after = 1'b0;
            end
        end
        chk("fair grants", ngr, 6);
        chk("fair rsps", nrsp, 6);
        for (int i = 0; i < 6; i++) begin
            if (i < ngr) chk($sformatf("fair grant %0d", i), {31'd0, gq[i]}, i % 2);
            if (i < nrsp) chk($sformatf("fair rsp %0d", i), {31'd0, rq[i]}, i % 2);
            $display("txn fair %0d: granted port %0d", i, (i < ngr) ? int'(gq[i]) : -1);
        end
        chk("fair strobes", stb_cyc.size(), 6);
        for (int i = 1; i < stb_cyc.size(); i++) begin
            chk($sformatf("fair stb gap %0d", i), stb_cyc[i] - stb_cyc[i-1], 5);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
